// File: rtl/deserializer_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: framing FSM
// state encoding and the default data word width.
package deserializer_pkg;

  localparam int BITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DISCARD = 2'd2
  } state_t;

endpackage

// File: rtl/deserializer_out_buf.sv
// One-entry valid/ready output register. A word arriving while the entry is
// occupied and not being consumed is dropped and flagged with an overrun pulse.
module out_buf
  import deserializer_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [BITS-1:0] din,
  input  logic            dout_ready,
  output logic [BITS-1:0] dout,
  output logic            dout_valid,
  output logic            overrun
);

  logic take;

  assign take = dout_valid & dout_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= load & dout_valid & ~dout_ready;
      // A load coinciding with a handshake replaces the consumed word directly.
      if (load && (!dout_valid || dout_ready)) begin
        dout       <= din;
        dout_valid <= 1'b1;
      end else if (take) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/deserializer.sv
// LSB-first serial-to-parallel deserializer with sin_last framing checks.
// Optional even-parity bit per frame when DESERIALIZER_PARITY_EN is defined.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sin,
  input  logic            sin_valid,
  input  logic            sin_last,
  output logic [BITS-1:0] dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            frame_err,
  output logic            overrun,
  output logic            parity_err
);

`ifdef DESERIALIZER_PARITY_EN
  localparam int LEN = BITS + 1;
`else
  localparam int LEN = BITS;
`endif
  localparam int            CW   = $clog2(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [LEN-1:0] shift_q, shift_d, frame;
  logic           done, load, frame_err_d;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    frame       = shift_q;
    done        = 1'b0;
    frame_err_d = 1'b0;
    // frame is the shift register with the current bit already in place, so a
    // completing word is available in the same cycle its last bit arrives.
    for (int unsigned i = 0; i < LEN; i++) begin
      if (count_q == CW'(i)) frame[i] = sin;
    end
    if (sin_valid) begin
      case (state_q)
        IDLE, SHIFT: begin
          if (count_q == LAST) begin
            count_d = '0;
            shift_d = '0;
            if (sin_last) begin
              state_d = IDLE;
              done    = 1'b1;
            end else begin
              state_d     = DISCARD;
              frame_err_d = 1'b1;
            end
          end else if (sin_last) begin
            state_d     = IDLE;
            count_d     = '0;
            shift_d     = '0;
            frame_err_d = 1'b1;
          end else begin
            state_d = SHIFT;
            count_d = count_q + CW'(1);
            shift_d = frame;
          end
        end
        DISCARD: begin
          if (sin_last) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
          shift_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      shift_q   <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      frame_err <= frame_err_d;
    end
  end

`ifdef DESERIALIZER_PARITY_EN
  logic parity_ok;

  assign parity_ok = ((^frame[BITS-1:0]) == frame[LEN-1]);
  assign load      = done & parity_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= done & ~parity_ok;
  end
`else
  assign load       = done;
  assign parity_err = 1'b0;
`endif

  out_buf #(.BITS(BITS)) u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .din        (frame[BITS-1:0]),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer (BITS=8): table of frames with expected
// outputs plus hand-written gap, back-to-back and mid-frame reset sequences.
module tb_deserializer;

`ifdef DESERIALIZER_PARITY_EN
  localparam int LEN = 9;
`else
  localparam int LEN = 8;
`endif
  localparam int K_GOOD   = 0;
  localparam int K_SHORT  = 1;
  localparam int K_LONG   = 2;
  localparam int K_BADPAR = 3;

  typedef struct {
    logic [7:0] data;
    int         kind;
    logic       rdy;
    logic       rdy_last;
    logic       exp_pre;
    logic       exp_valid;
    logic [7:0] exp_dout;
    int         exp_ferr;
    int         exp_ovr;
    int         exp_perr;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin, sin_valid, sin_last, dout_ready;
  logic [7:0] dout;
  logic       dout_valid, frame_err, overrun, parity_err;

  int checks = 0;
  int errors = 0;
  int n_ferr, n_ovr, n_perr;
  rec_t tbl[$];

  always #5 clk = ~clk;

  deserializer #(.BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_last   (sin_last),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] frame_bits(input logic [7:0] d);
    logic [15:0] f;
    f = {8'h00, d};
`ifdef DESERIALIZER_PARITY_EN
    f[8] = ^d;
`endif
    return f;
  endfunction

  // Samples the previous edge's pulse outputs, then applies new inputs.
  task automatic drive(input logic s, input logic v, input logic l, input logic r);
    @(negedge clk);
    n_ferr += int'(frame_err);
    n_ovr  += int'(overrun);
    n_perr += int'(parity_err);
    sin        = s;
    sin_valid  = v;
    sin_last   = l;
    dout_ready = r;
  endtask

  task automatic send_word(input logic [7:0] d, input int gap, input logic r);
    logic [15:0] fb;
    fb = frame_bits(d);
    for (int i = 0; i < LEN; i++) begin
      repeat (gap) drive(1'($urandom), 1'b0, 1'b1, r);
      drive(fb[i], 1'b1, i == LEN - 1, r);
    end
  endtask

  task automatic run_rec(input int idx, input rec_t r);
    logic [15:0] fb;
    int n, last;
    logic pre;
    fb   = frame_bits(r.data);
    n    = LEN;
    last = LEN - 1;
    case (r.kind)
      K_SHORT: begin n = 5; last = 4; end
      K_LONG: begin fb[LEN] = 1'b1; n = LEN + 1; last = LEN; end
      K_BADPAR: fb[LEN-1] = ~fb[LEN-1];
      default: ;
    endcase
    n_ferr = 0; n_ovr = 0; n_perr = 0; pre = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive(fb[i], 1'b1, i == last, (i == n - 1) ? r.rdy_last : r.rdy);
      if (i == n - 1) pre = dout_valid;
    end
    drive(1'b0, 1'b0, 1'b0, r.rdy_last);
    check($sformatf("rec%0d pre_valid", idx), 32'(pre), 32'(r.exp_pre));
    check($sformatf("rec%0d dout_valid", idx), 32'(dout_valid), 32'(r.exp_valid));
    if (r.exp_valid) check($sformatf("rec%0d dout", idx), 32'(dout), 32'(r.exp_dout));
    check($sformatf("rec%0d frame_err_pulses", idx), n_ferr, r.exp_ferr);
    check($sformatf("rec%0d overrun_pulses", idx), n_ovr, r.exp_ovr);
    check($sformatf("rec%0d parity_err_pulses", idx), n_perr, r.exp_perr);
  endtask

  initial begin
    logic [15:0] fb;
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sin_last = 1'b0; dout_ready = 1'b0;

    // data, kind, rdy, rdy_last, pre, valid, dout, ferr, ovr, perr
    tbl.push_back('{8'hA5, K_GOOD,  1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 0, 0, 0});
    tbl.push_back('{8'h1F, K_SHORT, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1, 0, 0});
    tbl.push_back('{8'h3C, K_GOOD,  1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 0, 0, 0});
    tbl.push_back('{8'hAB, K_LONG,  1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1, 0, 0});
    tbl.push_back('{8'h01, K_GOOD,  1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 0, 0, 0});
    tbl.push_back('{8'h11, K_GOOD,  1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 0, 0, 0});
    tbl.push_back('{8'h22, K_GOOD,  1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 0, 1, 0});
    tbl.push_back('{8'h22, K_GOOD,  1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 0, 0, 0});
`ifdef DESERIALIZER_PARITY_EN
    tbl.push_back('{8'h07, K_BADPAR, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0, 1});
    tbl.push_back('{8'h07, K_GOOD,   1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 0, 0, 0});
`endif

    @(negedge clk);
    check("reset dout", 32'(dout), 32'h0);
    check("reset dout_valid", 32'(dout_valid), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    check("reset overrun", 32'(overrun), 32'h0);
    check("reset parity_err", 32'(parity_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < tbl.size(); k++) run_rec(k, tbl[k]);

    // Bits spread out with invalid cycles carrying sin_last=1 and random sin.
    send_word(8'h96, 2, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("gap dout_valid", 32'(dout_valid), 32'h1);
    check("gap dout", 32'(dout), 32'h96);

    // Back-to-back frames with no idle cycle in between.
    n_ferr = 0;
    send_word(8'h5A, 0, 1'b1);
    fb = frame_bits(8'hC3);
    drive(fb[0], 1'b1, 1'b0, 1'b1);
    check("b2b first dout_valid", 32'(dout_valid), 32'h1);
    check("b2b first dout", 32'(dout), 32'h5A);
    for (int i = 1; i < LEN; i++) drive(fb[i], 1'b1, i == LEN - 1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("b2b second dout_valid", 32'(dout_valid), 32'h1);
    check("b2b second dout", 32'(dout), 32'hC3);
    check("b2b frame_err_pulses", n_ferr, 0);

    // Held word plus partial frame, then asynchronous reset between edges.
    send_word(8'h99, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("held dout", 32'(dout), 32'h99);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async rst dout", 32'(dout), 32'h0);
    check("async rst dout_valid", 32'(dout_valid), 32'h0);
    check("async rst frame_err", 32'(frame_err), 32'h0);
    check("async rst overrun", 32'(overrun), 32'h0);
    check("async rst parity_err", 32'(parity_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sin_valid = 1'b0;
    send_word(8'h7E, 0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("post rst dout_valid", 32'(dout_valid), 32'h1);
    check("post rst dout", 32'(dout), 32'h7E);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("drained dout_valid", 32'(dout_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have parameter BITS, default 8, giving data word width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port sin  input  1  serial data bit, LSB first.
REQ-005 SHALL have port sin_valid  input  1  sin is meaningful this cycle; bit accepted when high.
REQ-006 SHALL have port sin_last  input  1  qualified by sin_valid; marks final bit of a frame.
REQ-007 SHALL have port dout  output  BITS  assembled word held in output buffer.
REQ-008 SHALL have port dout_valid  output  1  output buffer holds an unconsumed word.
REQ-009 SHALL have port dout_ready  input  1  consumer takes word when dout_valid and dout_ready are both high.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on frame length error.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a completed word is dropped.
REQ-012 SHALL have port parity_err  output  1  one-cycle pulse on parity mismatch (see Configuration).

Function
REQ-013 SHALL implement states IDLE (no bits held), SHIFT (0 < count < frame length), DISCARD (waiting for sin_last after an overlong frame).
REQ-014 Each accepted bit SHALL be written to shift position count, and count SHALL increment; with sin_valid low, count, state and shift register SHALL hold.
REQ-015 Frame length SHALL be BITS (BITS+1 with parity); a frame completes when the bit at count == length-1 is accepted with sin_last high.
REQ-016 sin_last on an accepted bit with count < length-1 SHALL pulse frame_err the next cycle, discard the partial word, and return to IDLE with count 0.
REQ-017 Bit at count == length-1 accepted without sin_last SHALL pulse frame_err, discard the word, and enter DISCARD; DISCARD ignores bits until an accepted sin_last, then returns to IDLE.
REQ-018 A completed word SHALL appear on dout with dout_valid high the cycle after its final bit is accepted (latency 1).
REQ-019 dout and dout_valid SHALL hold stable until the handshake; on handshake with no new word, dout_valid SHALL drop next cycle.
REQ-020 Completion while buffer is full and dout_ready low SHALL drop the new word, keep the old one, and pulse overrun.
REQ-021 Completion in the same cycle as a handshake SHALL load the new word without overrun; dout_valid stays high.
REQ-022 Back-to-back frames SHALL be accepted with no idle cycle between final bit and next first bit.
REQ-023 frame_err, overrun and parity_err SHALL never be asserted longer than one cycle per event.

Reset
REQ-024 rst high SHALL, asynchronously, force state IDLE, count 0, shift register 0, dout 0, dout_valid 0, frame_err/overrun/parity_err 0.
REQ-025 Reset mid-frame or with a held word SHALL discard all content; first accepted bit after release is bit 0 of a new frame.

Configuration
REQ-026 Macro DESERIALIZER_PARITY_EN defined: frame carries one even-parity bit after the BITS data bits; on mismatch, word is discarded, parity_err pulses, no dout_valid.
REQ-027 Macro undefined: frame is BITS data bits only; parity_err SHALL be tied 0; no parity logic synthesized.

Structure
REQ-028 Package deserializer_pkg SHALL hold the state encoding (IDLE, SHIFT, DISCARD) and default width constant BITS_DEFAULT = 8.
REQ-029 Output buffer/handshake SHALL be a sub-module out_buf (one-entry valid/ready register with overrun detect); framing FSM stays in deserializer.

Verification
REQ-030 BITS=8, send 0xA5 LSB first, sin_last on bit 7, dout_ready high -> dout=0xA5, dout_valid high exactly one cycle after bit 7.
REQ-031 sin_last on bit 4 -> frame_err pulse, no dout_valid; next clean frame 0x3C -> dout=0x3C.
REQ-032 9 bits, no sin_last on bit 7, sin_last on bit 8 -> frame_err pulse once, DISCARD until bit 8, next frame 0x01 received correctly.
REQ-033 dout_ready low, two frames 0x11 then 0x22 -> dout stays 0x11, overrun pulse at second completion; repeat with dout_ready high at completion -> dout=0x22, no overrun.
REQ-034 rst asserted after bit 3 of a frame -> all outputs 0 immediately (before next clk edge); subsequent frame 0x7E received correctly.
REQ-035 With DESERIALIZER_PARITY_EN, 0x07 with parity bit 0 (wrong) -> parity_err pulse, no dout_valid; with parity 1 -> dout=0x07.
